// File: rtl/regfile_pkg.sv
// Shared types and register indices for the ARM-style register file and its performance counters.
package regfile_pkg;

  typedef enum logic [2:0] {
    T_ALU_R = 3'b000,
    T_ALU_I = 3'b001,
    T_LOAD  = 3'b100,
    T_STORE = 3'b101,
    T_NOP   = 3'b111
  } type_e;

  localparam logic [4:0] PC_IDX  = 5'd15;
  localparam logic [4:0] CNT_ALU = 5'd28;
  localparam logic [4:0] CNT_LD  = 5'd29;
  localparam logic [4:0] CNT_ST  = 5'd30;

  localparam logic [1:0] SW_CLEAR = 2'b11;

endpackage

// File: rtl/perf_counters.sv
// Instruction-class counter decode: produces next values and override strobes for R28-R30.
module perf_counters
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2:0]       i_type,
  input  logic [1:0]       i_sw,
  input  logic [WIDTH-1:0] i_cnt_alu,
  input  logic [WIDTH-1:0] i_cnt_ld,
  input  logic [WIDTH-1:0] i_cnt_st,
  output logic [WIDTH-1:0] o_next_alu,
  output logic [WIDTH-1:0] o_next_ld,
  output logic [WIDTH-1:0] o_next_st,
  output logic [2:0]       o_ovr
);

  logic w_clear;
  logic w_inc_alu;
  logic w_inc_ld;
  logic w_inc_st;

  always_comb begin
    w_clear   = (i_sw == SW_CLEAR);
    w_inc_alu = (i_type == T_ALU_R) || (i_type == T_ALU_I);
    w_inc_ld  = (i_type == T_LOAD);
    w_inc_st  = (i_type == T_STORE);

    // Clear beats increment; either one overrides an architectural write.
    o_next_alu = w_clear ? '0 : i_cnt_alu + WIDTH'(1);
    o_next_ld  = w_clear ? '0 : i_cnt_ld + WIDTH'(1);
    o_next_st  = w_clear ? '0 : i_cnt_st + WIDTH'(1);
    o_ovr      = {w_clear | w_inc_st, w_clear | w_inc_ld, w_clear | w_inc_alu};
  end

endmodule

// File: rtl/reg_file.sv
// 32-entry register file: falling-edge write-first, R15 reads PC+8, R28-R30 count instruction classes.
module reg_file
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             RegWriteW,
  input  logic [4:0]       RA1D,
  input  logic [4:0]       RA2D,
  input  logic [4:0]       WA3W,
  input  logic [WIDTH-1:0] ResultW,
  input  logic [WIDTH-1:0] PCPlus8D,
  output logic [WIDTH-1:0] RD1D,
  output logic [WIDTH-1:0] RD2D,
  output logic [7:0]       LEDs,
  input  logic [2:0]       Switches,
  input  logic [2:0]       Type
);

  logic [WIDTH-1:0] r_rf [NREGS];

  logic [WIDTH-1:0] w_next_alu;
  logic [WIDTH-1:0] w_next_ld;
  logic [WIDTH-1:0] w_next_st;
  logic [2:0]       w_ovr;
  logic [15:0]      w_led_cnt;

  perf_counters #(
    .WIDTH(WIDTH)
  ) u_perf_counters (
    .i_type    (Type),
    .i_sw      (Switches[1:0]),
    .i_cnt_alu (r_rf[CNT_ALU]),
    .i_cnt_ld  (r_rf[CNT_LD]),
    .i_cnt_st  (r_rf[CNT_ST]),
    .o_next_alu(w_next_alu),
    .o_next_ld (w_next_ld),
    .o_next_st (w_next_st),
    .o_ovr     (w_ovr)
  );

  // Falling-edge update lets decode read the writeback value in the same cycle.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        r_rf[i] <= '0;
      end
    end else begin
      if (RegWriteW && (WA3W != PC_IDX)) begin
        r_rf[WA3W] <= ResultW;
      end
      // Later assignments win, giving counter updates priority over ResultW.
      if (w_ovr[0]) r_rf[CNT_ALU] <= w_next_alu;
      if (w_ovr[1]) r_rf[CNT_LD]  <= w_next_ld;
      if (w_ovr[2]) r_rf[CNT_ST]  <= w_next_st;
    end
  end

  always_comb begin
    RD1D = (RA1D == PC_IDX) ? PCPlus8D : r_rf[RA1D];
    RD2D = (RA2D == PC_IDX) ? PCPlus8D : r_rf[RA2D];
  end

  always_comb begin
    w_led_cnt = '0;
    case (Switches[1:0])
      2'b00:   w_led_cnt = r_rf[CNT_ALU][15:0];
      2'b01:   w_led_cnt = r_rf[CNT_LD][15:0];
      2'b10:   w_led_cnt = r_rf[CNT_ST][15:0];
      default: w_led_cnt = '0;
    endcase
    LEDs = Switches[2] ? w_led_cnt[15:8] : w_led_cnt[7:0];
  end

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: expectations are queued with stimulus and checked after each edge.
module tb_reg_file;

  logic        clk;
  logic        reset;
  logic        RegWriteW;
  logic [4:0]  RA1D;
  logic [4:0]  RA2D;
  logic [4:0]  WA3W;
  logic [31:0] ResultW;
  logic [31:0] PCPlus8D;
  logic [31:0] RD1D;
  logic [31:0] RD2D;
  logic [7:0]  LEDs;
  logic [2:0]  Switches;
  logic [2:0]  Type;

  reg_file #(
    .WIDTH(32),
    .NREGS(32)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .RegWriteW(RegWriteW),
    .RA1D     (RA1D),
    .RA2D     (RA2D),
    .WA3W     (WA3W),
    .ResultW  (ResultW),
    .PCPlus8D (PCPlus8D),
    .RD1D     (RD1D),
    .RD2D     (RD2D),
    .LEDs     (LEDs),
    .Switches (Switches),
    .Type     (Type)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Scoreboard: port 0 = RD1D, 1 = RD2D, 2 = LEDs.
  string       q_tag  [$];
  int unsigned q_port [$];
  logic [31:0] q_exp  [$];

  logic [31:0] m_rf [32];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int unsigned port, input logic [31:0] exp);
    q_tag.push_back(tag);
    q_port.push_back(port);
    q_exp.push_back(exp);
  endtask

  task automatic drain();
    string       tag;
    int unsigned port;
    logic [31:0] exp;
    logic [31:0] obs;
    while (q_exp.size() > 0) begin
      tag  = q_tag.pop_front();
      port = q_port.pop_front();
      exp  = q_exp.pop_front();
      case (port)
        0:       obs = RD1D;
        1:       obs = RD2D;
        default: obs = {24'h0, LEDs};
      endcase
      check(tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a);
    return (a == 5'd15) ? PCPlus8D : m_rf[a];
  endfunction

  function automatic logic [31:0] m_leds();
    logic [31:0] c;
    case (Switches[1:0])
      2'b00:   c = m_rf[28];
      2'b01:   c = m_rf[29];
      2'b10:   c = m_rf[30];
      default: c = 32'h0;
    endcase
    return {24'h0, (Switches[2] ? c[15:8] : c[7:0])};
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
  endtask

  // Reference update at the falling edge: write, then increment, then clear (last one wins).
  task automatic m_edge();
    logic [31:0] o28, o29, o30;
    o28 = m_rf[28];
    o29 = m_rf[29];
    o30 = m_rf[30];
    if (RegWriteW === 1'b1 && WA3W != 5'd15) m_rf[WA3W] = ResultW;
    if (Type == 3'b000 || Type == 3'b001) m_rf[28] = o28 + 32'd1;
    if (Type == 3'b100) m_rf[29] = o29 + 32'd1;
    if (Type == 3'b101) m_rf[30] = o30 + 32'd1;
    if (Switches[1:0] == 2'b11) begin
      m_rf[28] = 32'h0;
      m_rf[29] = 32'h0;
      m_rf[30] = 32'h0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    m_edge();
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    RegWriteW = 1'b0;
    RA1D      = '0;
    RA2D      = '0;
    WA3W      = '0;
    ResultW   = '0;
    PCPlus8D  = 32'h0000_0108;
    Switches  = 3'b000;
    Type      = 3'b111;
    m_clear();
    #12;
    reset = 1'b0;

    // Reset state of every register on both ports.
    for (int a = 0; a < 32; a++) begin
      RA1D = 5'(a);
      RA2D = 5'(31 - a);
      #1;
      push($sformatf("reset_rd1_r%0d", a), 0, (a == 15) ? 32'h0000_0108 : 32'h0);
      push($sformatf("reset_rd2_r%0d", 31 - a), 1, (a == 16) ? 32'h0000_0108 : 32'h0);
      drain();
    end
    push("reset_leds", 2, 32'h0);
    drain();

    // Write-first read of R5.
    RegWriteW = 1'b1;
    WA3W      = 5'd5;
    ResultW   = 32'hDEAD_BEEF;
    RA1D      = 5'd5;
    push("write_first_r5", 0, 32'hDEAD_BEEF);
    tick();
    drain();

    // Writes to R15 are dropped.
    WA3W    = 5'd15;
    ResultW = 32'h1234_5678;
    RA1D    = 5'd15;
    push("r15_reads_pc", 0, 32'h0000_0108);
    tick();
    drain();
    RegWriteW = 1'b0;

    // Clear, then one of each instruction class.
    Switches = 3'b011;
    tick();
    Switches = 3'b000;
    Type = 3'b000; tick();
    Type = 3'b001; tick();
    Type = 3'b100; tick();
    Type = 3'b101; tick();
    Type = 3'b111; tick();
    Switches = 3'b000; #1; push("led_alu", 2, 32'h02); drain();
    Switches = 3'b001; #1; push("led_ld", 2, 32'h01); drain();
    Switches = 3'b010; #1; push("led_st", 2, 32'h01); drain();
    Switches = 3'b011; #1; push("led_sel11", 2, 32'h00); drain();
    Switches = 3'b000;

    // Architectural write to R28, then increment across a byte boundary.
    RegWriteW = 1'b1;
    WA3W      = 5'd28;
    ResultW   = 32'h0000_12FF;
    RA1D      = 5'd28;
    push("r28_write", 0, 32'h0000_12FF);
    tick();
    drain();
    RegWriteW = 1'b0;
    Type = 3'b000;
    push("r28_inc", 0, 32'h0000_1300);
    tick();
    drain();
    Type = 3'b111;
    Switches = 3'b100; #1; push("led_hi_byte", 2, 32'h13); drain();
    Switches = 3'b000;

    // R29 wraps modulo 2^32.
    RegWriteW = 1'b1;
    WA3W      = 5'd29;
    ResultW   = 32'hFFFF_FFFF;
    RA1D      = 5'd29;
    push("r29_write", 0, 32'hFFFF_FFFF);
    tick();
    drain();
    RegWriteW = 1'b0;
    Type = 3'b100;
    push("r29_wrap", 0, 32'h0);
    tick();
    drain();

    // Increment beats a same-edge ResultW write to R30 (R30 was 1).
    RegWriteW = 1'b1;
    WA3W      = 5'd30;
    ResultW   = 32'hAAAA_5555;
    Type      = 3'b101;
    RA2D      = 5'd30;
    push("r30_inc_over_write", 1, 32'h2);
    tick();
    drain();

    // Clear beats a same-edge increment.
    Switches = 3'b011;
    Type     = 3'b000;
    WA3W     = 5'd28;
    RA1D     = 5'd28;
    push("clear_over_inc", 0, 32'h0);
    tick();
    drain();
    RegWriteW = 1'b0;
    Switches  = 3'b000;
    Type      = 3'b111;

    // Randomised traffic against the reference model.
    for (int n = 0; n < 300; n++) begin
      RegWriteW = 1'($urandom_range(0, 1));
      WA3W      = 5'($urandom_range(0, 31));
      ResultW   = $urandom;
      PCPlus8D  = $urandom;
      Type      = 3'($urandom_range(0, 7));
      Switches  = 3'($urandom_range(0, 7));
      RA1D      = 5'($urandom_range(0, 31));
      RA2D      = ($urandom_range(0, 3) == 0) ? 5'd15 : 5'($urandom_range(28, 30));
      tick();
      push($sformatf("rand_rd1_%0d", n), 0, m_read(RA1D));
      push($sformatf("rand_rd2_%0d", n), 1, m_read(RA2D));
      push($sformatf("rand_leds_%0d", n), 2, m_leds());
      drain();
    end

    // Asynchronous reset between edges.
    RegWriteW = 1'b1;
    WA3W      = 5'd5;
    ResultW   = 32'h0000_0055;
    Switches  = 3'b000;
    Type      = 3'b000;
    tick();
    RegWriteW = 1'b0;
    Type      = 3'b111;
    RA1D      = 5'd5;
    #1;
    push("pre_reset_rd1", 0, m_read(5'd5));
    push("pre_reset_leds", 2, m_leds());
    drain();
    #1;
    reset = 1'b1;
    m_clear();
    #1;
    push("async_reset_rd1", 0, 32'h0);
    push("async_reset_leds", 2, 32'h0);
    drain();
    #1;
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
